muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op_code constants and FSM state encoding for muldiv_unit.
package muldiv_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_MULT  = 3'b000;
  localparam logic [OP_W-1:0] OP_MULTU = 3'b001;
  localparam logic [OP_W-1:0] OP_DIV   = 3'b010;
  localparam logic [OP_W-1:0] OP_DIVU  = 3'b011;
  localparam logic [OP_W-1:0] OP_MTHI  = 3'b100;
  localparam logic [OP_W-1:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on the shared 2*WIDTH accumulator.
//   is_div   : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc      : current accumulator {upper, lower}
//   opnd     : multiplicand magnitude (mul) or divisor magnitude (div)
//   acc_next : accumulator after this step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] add_sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    // Multiply: lower half holds the multiplier, its LSB gates the add, then shift right.
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Divide: shift the next dividend bit into the partial remainder.
    rem     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff    = rem - {1'b0, opnd};
    if (is_div) begin
      // diff[WIDTH] set means rem < divisor: restore and shift in a 0 quotient bit.
      if (diff[WIDTH]) begin
        acc_next = {rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style HI/LO multiply/divide unit.
//   clock, reset_n      : clock and asynchronous active-low reset
//   op_valid, op_code   : request strobe and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   op_a, op_b          : rs / rt operand values, captured at acceptance
//   cancel              : flush; aborts an in-flight operation, blocks acceptance in IDLE
//   op_ready, busy      : handshake / in-flight status
//   done                : one-cycle pulse after HI/LO receive a MULT/DIV result
//   hi, lo              : architectural HI/LO registers
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             op_valid,
  input  logic [OP_W-1:0]  op_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cancel,
  output logic             op_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             is_div_q, is_div_d;
  logic             sign_res_q, sign_res_d;
  logic             sign_rem_q, sign_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;

  logic             is_signed;
  logic             req_div;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [ACC_W-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div_q),
    .acc      (acc_step_in()),
    .opnd     (opnd_q),
    .acc_next (acc_step)
  );

  function automatic logic [ACC_W-1:0] acc_step_in();
    return acc_q;
  endfunction

  // Request decode and sign-corrected results.
  always_comb begin
    is_signed = (op_code == OP_MULT) || (op_code == OP_DIV);
    req_div   = op_code[1];
    mag_a     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    prod_fix  = sign_res_q ? -acc_q : acc_q;
    quot_fix  = sign_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix   = sign_rem_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];
  end

  // Next-state and output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    sign_res_d = sign_res_q;
    sign_rem_d = sign_rem_q;
    div0_d     = div0_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid && !cancel) begin
          if (!op_code[2]) begin
            // Lower half holds the multiplier (mul) or dividend (div).
            state_d    = RUN;
            cnt_d      = CNT_W'(WIDTH);
            is_div_d   = req_div;
            opnd_d     = req_div ? mag_b : mag_a;
            acc_d      = {{WIDTH{1'b0}}, (req_div ? mag_a : mag_b)};
            sign_res_d = is_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            sign_rem_d = is_signed && op_a[WIDTH-1];
            div0_d     = req_div && (op_b == '0);
            busy_d     = 1'b1;
            ready_d    = 1'b0;
          end else if (op_code == OP_MTHI) begin
            hi_d = op_a;
          end else if (op_code == OP_MTLO) begin
            lo_d = op_a;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // Divide-by-zero leaves the dividend magnitude in the upper half, so the
            // remainder sign fix reproduces op_a exactly; quotient is forced to all ones.
            hi_d = rem_fix;
            lo_d = div0_q ? '1 : quot_fix;
          end else begin
            {hi_d, lo_d} = prod_fix;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      sign_res_q <= 1'b0;
      sign_rem_q <= 1'b0;
      div0_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      sign_res_q <= sign_res_d;
      sign_rem_q <= sign_rem_d;
      div0_q     <= div0_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
    end
  end

  assign op_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit (WIDTH=32) against an
// arithmetic reference model of HI/LO results and handshake timing.
module tb_muldiv_unit;

  localparam int unsigned W = 32;

  localparam logic [2:0] C_MULT  = 3'b000;
  localparam logic [2:0] C_MULTU = 3'b001;
  localparam logic [2:0] C_DIV   = 3'b010;
  localparam logic [2:0] C_DIVU  = 3'b011;
  localparam logic [2:0] C_MTHI  = 3'b100;
  localparam logic [2:0] C_MTLO  = 3'b101;

  logic         clock    = 1'b0;
  logic         reset_n  = 1'b1;
  logic         op_valid = 1'b0;
  logic [2:0]   op_code  = 3'b000;
  logic [W-1:0] op_a     = '0;
  logic [W-1:0] op_b     = '0;
  logic         cancel   = 1'b0;
  logic         op_ready, busy, done;
  logic [W-1:0] hi, lo;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_hi   = '0;
  logic [W-1:0] exp_lo   = '0;

  muldiv_unit #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_a     (op_a),
    .op_b     (op_b),
    .cancel   (cancel),
    .op_ready (op_ready),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] h,
                                output logic [W-1:0] l);
    longint       sa, sb, q, r;
    logic [63:0]  p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    h  = '0;
    l  = '0;
    case (op)
      C_MULT: begin
        p = 64'(sa * sb);
        {h, l} = p;
      end
      C_MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        {h, l} = p;
      end
      C_DIV, C_DIVU: begin
        if (b == '0) begin
          h = a;
          l = '1;
        end else begin
          if (op == C_DIVU) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          l = q[31:0];
          h = r[31:0];
        end
      end
      default: ;
    endcase
  endfunction

  task automatic wait_ready();
    int g = 0;
    while (!op_ready && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (!op_ready) chk("ready_timeout", 64'(op_ready), 64'd1);
  endtask

  // Issue a MULT/DIV op and check exact latency, done pulse and HI/LO.
  task automatic arith(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int bad = 0;
    model(op, a, b, eh, el);
    @(negedge clock);
    wait_ready();
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = b;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
    if (!busy || done || op_ready) bad++;
    repeat (W) begin
      @(posedge clock);
      #1;
      if (!busy || done || op_ready) bad++;
    end
    @(posedge clock);
    #1;
    chk("busy_window", 64'(bad), 64'd0);
    chk("done_at_end", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    exp_hi = eh;
    exp_lo = el;
    @(posedge clock);
    #1;
    chk("done_pulse", 64'(done), 64'd0);
  endtask

  // Single-cycle op (MTHI/MTLO/reserved), optionally with a same-cycle cancel.
  task automatic single(input logic [2:0] op, input logic [W-1:0] a, input logic cx);
    @(negedge clock);
    wait_ready();
    op_valid = 1'b1;
    op_code  = op;
    op_a     = a;
    op_b     = $urandom;
    cancel   = cx;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    cancel   = 1'b0;
    if (!cx && op == C_MTHI) exp_hi = a;
    if (!cx && op == C_MTLO) exp_lo = a;
    chk("single_hi", 64'(hi), 64'(exp_hi));
    chk("single_lo", 64'(lo), 64'(exp_lo));
    chk("single_busy", 64'(busy), 64'd0);
    chk("single_done", 64'(done), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = 32'h0000_0001;
      2:       v = '1;
      3:       v = 32'h8000_0000;
      4:       v = 32'h0000_0000 + W'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int g;
    int seen;
    logic [W-1:0] a, b;
    logic [2:0] op;

    // Reset values, checked before any clock edge.
    #3 reset_n = 1'b0;
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(op_ready), 64'd1);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Directed corner cases.
    arith(C_MULT,  32'hFFFF_FFFF, 32'h0000_0002);
    arith(C_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    arith(C_DIV,   32'hFFFF_FFF9, 32'h0000_0002);
    arith(C_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    arith(C_DIVU,  32'h0000_0005, 32'h0000_0000);
    arith(C_DIV,   32'hFFFF_FFF9, 32'h0000_0000);
    arith(C_MULT,  32'h8000_0000, 32'h8000_0000);

    // Randomized mix.
    for (int i = 0; i < 60; i++) begin
      a = rnd_opnd();
      b = rnd_opnd();
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          op = 3'($urandom_range(0, 3));
          arith(op, a, b);
        end
        6:       single(C_MTHI, a, 1'b0);
        7:       single(C_MTLO, a, 1'b0);
        8:       single(3'b110 + 3'($urandom_range(0, 1)), a, 1'b0);
        default: single(C_MTHI, a, 1'b1);
      endcase
    end

    // MTLO held while busy is taken only after the multiply completes.
    @(negedge clock);
    wait_ready();
    op_valid = 1'b1;
    op_code  = C_MULTU;
    op_a     = 32'd3;
    op_b     = 32'd4;
    @(posedge clock);
    #1;
    op_code = C_MTLO;
    op_a    = 32'h55;
    g       = 0;
    seen    = 0;
    while (!done && g < 100) begin
      @(posedge clock);
      #1;
      g++;
      if (!done && lo !== exp_lo) seen++;
    end
    chk("hold_done", 64'(done), 64'd1);
    chk("hold_lo_stable", 64'(seen), 64'd0);
    chk("hold_mul_lo", 64'(lo), 64'd12);
    chk("hold_mul_hi", 64'(hi), 64'd0);
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    chk("hold_mtlo_lo", 64'(lo), 64'h55);
    chk("hold_mtlo_hi", 64'(hi), 64'd0);
    chk("hold_mtlo_busy", 64'(busy), 64'd0);
    exp_lo = 32'h55;
    exp_hi = '0;

    // Cancel during RUN cycle 10.
    single(C_MTHI, 32'h1234_5678, 1'b0);
    single(C_MTLO, 32'h9ABC_DEF0, 1'b0);
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = C_DIVU;
    op_a     = 32'd100;
    op_b     = 32'd7;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    cancel = 1'b1;
    @(posedge clock);
    #1;
    cancel = 1'b0;
    chk("cancel_busy", 64'(busy), 64'd0);
    chk("cancel_ready", 64'(op_ready), 64'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    chk("cancel_no_done", 64'(seen), 64'd0);
    chk("cancel_hi", 64'(hi), 64'(exp_hi));
    chk("cancel_lo", 64'(lo), 64'(exp_lo));

    // Cancel in IDLE blocks a same-cycle multiply too.
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = C_MULTU;
    op_a     = 32'd9;
    op_b     = 32'd9;
    cancel   = 1'b1;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    cancel   = 1'b0;
    chk("idle_cancel_busy", 64'(busy), 64'd0);
    chk("idle_cancel_lo", 64'(lo), 64'(exp_lo));

    // Reset mid-operation, then accept on the first edge after release.
    @(negedge clock);
    op_valid = 1'b1;
    op_code  = C_MULT;
    op_a     = 32'h0001_2345;
    op_b     = 32'h0000_0777;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    repeat (4) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_ready", 64'(op_ready), 64'd1);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clock);
    reset_n  = 1'b1;
    op_valid = 1'b1;
    op_code  = C_MULTU;
    op_a     = 32'd2;
    op_b     = 32'd3;
    @(posedge clock);
    #1;
    op_valid = 1'b0;
    chk("postrst_accept", 64'(busy), 64'd1);
    g = 0;
    while (!done && g < 100) begin
      @(posedge clock);
      #1;
      g++;
    end
    chk("postrst_done", 64'(done), 64'd1);
    chk("postrst_lat", 64'(g), 64'(W + 1));
    chk("postrst_lo", 64'(lo), 64'd6);
    chk("postrst_hi", 64'(hi), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
